pkt_sram_arbiter: RTL

PKT_SRAM_ARBITER -- requirements
Module: pkt_sram_arbiter

---
 rtl/switch_defs_pkg.sv | 32 +++
 rtl/pkt_sram_rr2.sv | 33 +++
 rtl/pkt_sram_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/switch_defs_pkg.sv
// ----------------------------------------------------------------------------
// switch_defs_pkg
// Definitions shared by the packet-switch SRAM path: default data widths,
// requester ids, the lock-state encoding, the outstanding-access record kept
// by the SRAM arbiter, and zero constants.
// ----------------------------------------------------------------------------
package switch_defs_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int SEL_W_DEF  = DATA_W_DEF / 8;

    // Requester ids double as the index into the per-requester port arrays.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_PKT = 1'b1;

    typedef enum logic [1:0] {
        LK_UNLOCKED = 2'd0,
        LK_LOCKED0  = 2'd1,
        LK_LOCKED1  = 2'd2
    } lock_state_e;

    // One slot of the outstanding-access pipeline.
    typedef struct packed {
        logic valid;
        logic id;
        logic we;
    } acc_t;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [15:0] ZERO_HALF = 16'h0000;

endpackage

// File: rtl/pkt_sram_rr2.sv
// ----------------------------------------------------------------------------
// pkt_sram_rr2
// Two-way round-robin picker. Requests masked by 'block' are ignored; a lone
// eligible request wins outright, and when both are eligible the requester
// that did not win most recently gets the grant.
//
// Ports:
//   req[1:0]    raw requests (0 = CPU, 1 = packet engine)
//   last_win    id of the most recent winner
//   block[1:0]  requesters excluded from this arbitration
//   gnt[1:0]    one-hot (or zero) grant
// ----------------------------------------------------------------------------
module pkt_sram_rr2 (
    input  logic [1:0] req,
    input  logic       last_win,
    input  logic [1:0] block,
    output logic [1:0] gnt
);

    logic [1:0] eligible;

    assign eligible = req & ~block;

    // NOTE: gnt is assigned before any branch so every path drives it and no
    // latch is inferred.
    always_comb begin
        gnt = eligible;
        if (&eligible) begin
            gnt = last_win ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/pkt_sram_arbiter.sv
// ----------------------------------------------------------------------------
// pkt_sram_arbiter
// Shares one single-port SRAM (1-cycle read latency) between the CPU
// (requester 0) and the packet engine (requester 1). One command is accepted
// per cycle; the winner's command is registered onto the SRAM pins the next
// cycle and read data returns to the issuing requester two cycles after grant.
//
// Build option: define PKT_SRAM_ARB_LOCK_EN to enable exclusive lock
// ownership with an idle timeout; otherwise lock_i is ignored and
// lock_err_o is tied low.
//
// Ports:
//   clk, rst                     clock; asynchronous active-low reset
//   req_i, we_i, lock_i [1:0]    per-requester request, write, hold-lock
//   addr_i, wdata_i, sel_i       per-requester command (held until granted)
//   gnt_o [1:0]                  command accepted this cycle (combinational)
//   rvalid_o [1:0], rdata_o      read return, shared data bus
//   lock_err_o                   one-cycle pulse on lock timeout
//   sram_ce_o ... sram_sel_o     registered SRAM command
//   sram_rdata_i                 SRAM read data
// ----------------------------------------------------------------------------
module pkt_sram_arbiter
    import switch_defs_pkg::*;
#(
    parameter  int ADDR_W   = 16,
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int LOCK_TMO = 64,
    localparam int SEL_W    = DATA_W / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_i,
    input  logic [1:0]             we_i,
    input  logic [1:0]             lock_i,
    input  logic [1:0][ADDR_W-1:0] addr_i,
    input  logic [1:0][DATA_W-1:0] wdata_i,
    input  logic [1:0][SEL_W-1:0]  sel_i,
    output logic [1:0]             gnt_o,
    output logic [1:0]             rvalid_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   lock_err_o,
    output logic                   sram_ce_o,
    output logic                   sram_we_o,
    output logic [ADDR_W-1:0]      sram_addr_o,
    output logic [DATA_W-1:0]      sram_wdata_o,
    output logic [SEL_W-1:0]       sram_sel_o,
    input  logic [DATA_W-1:0]      sram_rdata_i
);

    logic [1:0] rr_gnt;
    logic [1:0] block;
    logic       last_id;
    logic       win_id;
    logic       any_gnt;
    acc_t       s1;
    acc_t       s2;
    logic       s2_read;

    pkt_sram_rr2 u_rr (
        .req      (req_i),
        .last_win (last_id),
        .block    (block),
        .gnt      (rr_gnt)
    );

    // The grant is combinational, so it is forced low while reset is held.
    assign gnt_o   = rst ? rr_gnt : 2'b00;
    assign any_gnt = |gnt_o;
    assign win_id  = gnt_o[REQ_PKT];

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Pretend the packet engine won last so the CPU takes the first tie.
            last_id      <= REQ_PKT;
            sram_ce_o    <= 1'b0;
            sram_we_o    <= 1'b0;
            sram_addr_o  <= '0;
            sram_wdata_o <= '0;
            sram_sel_o   <= '0;
            s1           <= '0;
            s2           <= '0;
        end else begin
            sram_ce_o <= any_gnt;
            sram_we_o <= any_gnt & we_i[win_id];
            if (any_gnt) begin
                last_id      <= win_id;
                sram_addr_o  <= addr_i[win_id];
                sram_wdata_o <= wdata_i[win_id];
                sram_sel_o   <= sel_i[win_id];
            end
            // s1 tracks the access on the SRAM pins, s2 the one whose read
            // data the SRAM is returning now.
            s1 <= '{valid: any_gnt, id: win_id, we: we_i[win_id]};
            s2 <= s1;
        end
    end

    assign s2_read = s2.valid & ~s2.we;
    assign rdata_o = s2_read ? sram_rdata_i : '0;

    always_comb begin
        rvalid_o = 2'b00;
        if (s2_read) begin
            rvalid_o[s2.id] = 1'b1;
        end
    end

`ifdef PKT_SRAM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_TMO + 1);

    lock_state_e      lock_state;
    logic [CNT_W-1:0] idle_cnt;
    logic             locked;
    logic             owner;
    logic             tmo;

    assign locked = (lock_state != LK_UNLOCKED);
    assign owner  = (lock_state == LK_LOCKED1);
    // Fires in the LOCK_TMO-th consecutive idle cycle of the owner.
    assign tmo    = locked & ~req_i[owner] & (idle_cnt == CNT_W'(LOCK_TMO - 1));
    assign lock_err_o = tmo;

    always_comb begin
        block = 2'b00;
        if (lock_state == LK_LOCKED0) begin
            block[REQ_PKT] = 1'b1;
        end else if (lock_state == LK_LOCKED1) begin
            block[REQ_CPU] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_state <= LK_UNLOCKED;
            idle_cnt   <= '0;
        end else begin
            case (lock_state)
                LK_UNLOCKED: begin
                    if (any_gnt && lock_i[win_id]) begin
                        lock_state <= win_id ? LK_LOCKED1 : LK_LOCKED0;
                    end
                end
                default: begin
                    // The owner is never blocked, so a request from it is
                    // always granted here; its unlocked access releases.
                    if (gnt_o[owner]) begin
                        if (!lock_i[owner]) begin
                            lock_state <= LK_UNLOCKED;
                        end
                    end else if (tmo) begin
                        lock_state <= LK_UNLOCKED;
                    end
                end
            endcase

            if (locked && !req_i[owner] && !tmo) begin
                idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end
        end
    end
`else
    // Lock support not built: arbitration is pure round-robin.
    logic unused_lock;

    assign unused_lock = ^lock_i;
    assign block       = 2'b00;
    assign lock_err_o  = 1'b0;
`endif

endmodule
